contador_param: RTL and testbench
=================================

# contador_param

Parametrised successor of the 4-bit/16-bit mode counters: a WIDTH-bit synchronous counter with up, down, down-by-STEP and parallel-load modes. It provides a terminal ripple-carry flag plus per-nibble carry/borrow flags, so one instance replaces the hand-cascaded 16-bit counter. All outputs are registered. The block sits in the counter test suite and is driven by the same style of tester module as the earlier counters.

## Interface
- WIDTH, 16: counter width in bits; multiple of 4, range 4..64.
- STEP, 3: decrement applied in mode 2'b10; range 1..15.
- NIB, WIDTH/4: derived localparam, number of nibble slices.

- CLK  in  1  rising-edge clock.
- RESET_L  in  1  asynchronous, active-low reset.
- ENB  in  1  count enable; 0 = hold.
- MODO  in  2  operation select, sampled on each CLK edge.
- D  in  WIDTH  parallel-load value, sampled only in mode 2'b11.
- Q  out  WIDTH  counter value.
- RCO  out  1  registered wrap flag for the full width.
- RCO_NIB  out  NIB  registered carry/borrow out of each nibble; bit i covers Q[4i+3:4i].

## Operation
- Reset, RESET_L=0: Q=0, RCO=0, RCO_NIB=0 immediately, regardless of CLK.
- ENB=0: Q holds. RCO=0 and RCO_NIB=0 on the next edge. D and MODO are ignored.
- With ENB=1, on each rising CLK:
  - MODO=2'b00: Q <= Q+1. Overflow occurs when Q was all-ones; the result wraps to 0.
  - MODO=2'b01: Q <= Q-1. Underflow occurs when Q was 0; the result wraps to all-ones.
  - MODO=2'b10: Q <= Q-STEP, computed modulo 2^WIDTH. Underflow occurs when Q<STEP; for example, WIDTH=16, STEP=3, Q=1 gives 0xFFFE.
  - MODO=2'b11: Q <= D. RCO=0 and RCO_NIB=0; a load never flags.
- RCO is 1 for exactly the cycle in which Q holds the wrapped value. It returns to 0 on the next edge unless another wrap occurs.
- RCO_NIB[i] is the carry (up) or borrow (down modes) out of nibble i for that same operation. RCO_NIB[NIB-1] always equals RCO.
- Arithmetic is unsigned, WIDTH bits. No state other than Q and the flags is kept.
- A MODO change takes effect on the same edge at which it is sampled; there is no pipeline flush.

## Timing
- Latency is 1 cycle from sampled inputs to Q, RCO and RCO_NIB.
- There is no combinational path from any input to any output.
- Reset assertion is asynchronous. After deassertion, the first update happens at the first rising CLK with RESET_L=1.
- If RESET_L is asserted mid-operation, Q is cleared and any pending flag is lost. No recovery cycle is needed.
- If ENB and MODO change in the same cycle, the new values are both applied at that edge.

## Configuration
- CONTADOR_PARAM_SAT_EN defined: saturating counting replaces wrapping.
  - An up operation at all-ones leaves Q at all-ones.
  - A down or down-STEP operation that would underflow sets Q to 0.
  - On each clamped edge, RCO=1 and RCO_NIB has only bit NIB-1 set. RCO stays high every cycle the clamp repeats.
- Macro undefined: wrapping behaviour as specified under Operation.

## Structure
- Package contador_pkg holds the mode constants: MODO_UP=2'b00, MODO_DOWN=2'b01, MODO_DOWN_STEP=2'b10, MODO_LOAD=2'b11.
- Sub-module contador_nibble is a 4-bit slice.
  - Inputs: current nibble, operand nibble, direction, carry/borrow in.
  - Outputs: next nibble, carry/borrow out.
- The top level generate-cascades NIB slices. It selects the operand (1, STEP or D) and owns the Q/RCO/RCO_NIB registers and the saturation clamp.

## Test plan
All scenarios use WIDTH=16 and STEP=3.
- Reset mid-count: count up from 0 for 5 edges -> Q=0x0005. Pull RESET_L low between edges -> Q=0x0000 and RCO=0 immediately, without a CLK edge.
- Full wrap: load 0xFFFE, then MODO=00 -> Q=0xFFFF with RCO=0, then Q=0x0000 with RCO=1 and RCO_NIB=4'b1111, then Q=0x0001 with RCO=0.
- Nibble carry: load 0x00FF, MODO=00 -> Q=0x0100, RCO_NIB=4'b0011, RCO=0.
- Step underflow: load 0x0004, MODO=10 -> Q=0x0001, then Q=0xFFFE with RCO=1 and RCO_NIB=4'b1111.
- Hold: Q=0x1234, ENB=0 for 3 edges with MODO=00 and D toggling -> Q stays 0x1234, RCO=0 throughout.
- Saturation: load 0xFFFF, MODO=00 for 2 edges.
  - With CONTADOR_PARAM_SAT_EN: Q stays 0xFFFF, RCO=1 on both edges.
  - Without it: Q goes 0x0000 (RCO=1), then 0x0001 (RCO=0).

Source files
------------

// File: rtl/contador_pkg.sv
// Shared constants for the parametrised mode counter: operation selects and
// slice direction encoding.
package contador_pkg;

  localparam logic [1:0] MODO_UP        = 2'b00;
  localparam logic [1:0] MODO_DOWN      = 2'b01;
  localparam logic [1:0] MODO_DOWN_STEP = 2'b10;
  localparam logic [1:0] MODO_LOAD      = 2'b11;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/contador_nibble.sv
// 4-bit add/subtract slice; cout is the carry (up) or borrow (down) out of
// this nibble, fed to the next slice as its cin.
module contador_nibble
  import contador_pkg::*;
(
  input  logic [3:0] cur,
  input  logic [3:0] opnd,
  input  logic       dir,
  input  logic       cin,
  output logic [3:0] nxt,
  output logic       cout
);

  logic [4:0] res;

  // The 5th bit is the carry when adding and the borrow when subtracting.
  always_comb begin
    if (dir == DIR_DOWN) res = {1'b0, cur} - {1'b0, opnd} - {4'b0000, cin};
    else                 res = {1'b0, cur} + {1'b0, opnd} + {4'b0000, cin};
  end

  assign nxt  = res[3:0];
  assign cout = res[4];

endmodule

// File: rtl/contador_param.sv
// WIDTH-bit up/down/down-by-STEP/load counter built from cascaded nibble slices.
// Define CONTADOR_PARAM_SAT_EN to clamp at the range ends instead of wrapping.
module contador_param
  import contador_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int STEP  = 3
) (
  input  logic               CLK,
  input  logic               RESET_L,
  input  logic               ENB,
  input  logic [1:0]         MODO,
  input  logic [WIDTH-1:0]   D,
  output logic [WIDTH-1:0]   Q,
  output logic               RCO,
  output logic [WIDTH/4-1:0] RCO_NIB
);

  localparam int NIB = WIDTH / 4;

  logic [WIDTH-1:0] operand;
  logic [WIDTH-1:0] sum;
  logic [NIB:0]     chain;
  logic             dir;
  logic [WIDTH-1:0] q_nxt;
  logic             rco_nxt;
  logic [NIB-1:0]   nib_nxt;

  always_comb begin
    operand = '0;
    dir     = DIR_UP;
    case (MODO)
      MODO_UP:        operand = WIDTH'(1);
      MODO_DOWN: begin
        operand = WIDTH'(1);
        dir     = DIR_DOWN;
      end
      MODO_DOWN_STEP: begin
        operand = WIDTH'(STEP);
        dir     = DIR_DOWN;
      end
      default: ;
    endcase
  end

  assign chain[0] = 1'b0;

  for (genvar i = 0; i < NIB; i++) begin : g_nib
    contador_nibble u_nib (
      .cur  (Q[4*i +: 4]),
      .opnd (operand[4*i +: 4]),
      .dir  (dir),
      .cin  (chain[i]),
      .nxt  (sum[4*i +: 4]),
      .cout (chain[i+1])
    );
  end

  always_comb begin
    q_nxt   = Q;
    rco_nxt = 1'b0;
    nib_nxt = '0;
    if (ENB) begin
      if (MODO == MODO_LOAD) begin
        q_nxt = D;
      end else begin
        q_nxt   = sum;
        nib_nxt = chain[NIB:1];
        rco_nxt = chain[NIB];
`ifdef CONTADOR_PARAM_SAT_EN
        // A carry/borrow out of the top slice means the result left the range.
        if (chain[NIB]) begin
          q_nxt            = (dir == DIR_DOWN) ? '0 : '1;
          nib_nxt          = '0;
          nib_nxt[NIB-1]   = 1'b1;
        end
`endif
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) begin
      Q       <= '0;
      RCO     <= 1'b0;
      RCO_NIB <= '0;
    end else begin
      Q       <= q_nxt;
      RCO     <= rco_nxt;
      RCO_NIB <= nib_nxt;
    end
  end

endmodule

// File: tb/tb_contador_param.sv
// Self-checking bench for contador_param (WIDTH=16, STEP=3): directed scenarios
// plus randomized traffic against an arithmetic reference model.
module tb_contador_param;

  localparam int W  = 16;
  localparam int ST = 3;
  localparam int NB = W / 4;

  logic          CLK = 1'b0;
  logic          RESET_L = 1'b0;
  logic          ENB = 1'b0;
  logic [1:0]    MODO = 2'b00;
  logic [W-1:0]  D = '0;
  logic [W-1:0]  Q;
  logic          RCO;
  logic [NB-1:0] RCO_NIB;

  int checks = 0;
  int errors = 0;

  contador_param #(.WIDTH(W), .STEP(ST)) dut (
    .CLK     (CLK),
    .RESET_L (RESET_L),
    .ENB     (ENB),
    .MODO    (MODO),
    .D       (D),
    .Q       (Q),
    .RCO     (RCO),
    .RCO_NIB (RCO_NIB)
  );

  always #5 CLK = ~CLK;

  // Reference: plain modular arithmetic; nibble i flags whether the low 4(i+1)
  // bits of the operation overflowed (up) or went negative (down).
  function automatic void model(input logic [W-1:0] q, input logic enb,
                                input logic [1:0] modo, input logic [W-1:0] d,
                                output logic [W-1:0] nq, output logic nrco,
                                output logic [NB-1:0] nnib);
    longint op, m, lo, full;
    logic up;
    nq = q; nrco = 1'b0; nnib = '0;
    if (!enb) return;
    if (modo == 2'b11) begin
      nq = d;
      return;
    end
    up   = (modo == 2'b00);
    op   = (modo == 2'b10) ? longint'(ST) : 64'd1;
    full = longint'(1) << W;
    for (int i = 0; i < NB; i++) begin
      m  = longint'(1) << (4 * (i + 1));
      lo = longint'(q) % m;
      if (up) nnib[i] = ((lo + (op % m)) >= m);
      else    nnib[i] = (lo < (op % m));
    end
    if (up) nq = W'((longint'(q) + op) % full);
    else    nq = W'((longint'(q) + full - op) % full);
    nrco = nnib[NB-1];
`ifdef CONTADOR_PARAM_SAT_EN
    if (nrco) begin
      nq   = up ? '1 : '0;
      nnib = '0;
      nnib[NB-1] = 1'b1;
    end
`endif
  endfunction

  task automatic step(input logic enb, input logic [1:0] modo, input logic [W-1:0] d);
    ENB = enb; MODO = modo; D = d;
    @(posedge CLK);
    #1;
  endtask

  task automatic load(input logic [W-1:0] v);
    step(1'b1, 2'b11, v);
  endtask

  task automatic test_reset;
    #3;
    checks++; if (Q !== 16'h0000) begin errors++; $display("FAIL reset_q got %h exp 0000", Q); end
    checks++; if (RCO !== 1'b0) begin errors++; $display("FAIL reset_rco got %b exp 0", RCO); end
    checks++; if (RCO_NIB !== 4'b0000) begin errors++; $display("FAIL reset_nib got %b exp 0000", RCO_NIB); end
    @(negedge CLK);
    RESET_L = 1'b1;
    for (int i = 0; i < 5; i++) step(1'b1, 2'b00, '0);
    checks++; if (Q !== 16'h0005) begin errors++; $display("FAIL count5_q got %h exp 0005", Q); end
    load(16'hFFFF);
    step(1'b1, 2'b00, '0);
    #2 RESET_L = 1'b0;
    #1;
    checks++; if (Q !== 16'h0000) begin errors++; $display("FAIL async_reset_q got %h exp 0000", Q); end
    checks++; if (RCO !== 1'b0) begin errors++; $display("FAIL async_reset_rco got %b exp 0", RCO); end
    checks++; if (RCO_NIB !== 4'b0000) begin errors++; $display("FAIL async_reset_nib got %b exp 0000", RCO_NIB); end
    @(negedge CLK);
    RESET_L = 1'b1;
  endtask

  task automatic test_wrap;
    load(16'hFFFE);
    step(1'b1, 2'b00, '0);
    checks++; if (Q !== 16'hFFFF || RCO !== 1'b0) begin errors++; $display("FAIL wrap1 got q=%h rco=%b exp q=ffff rco=0", Q, RCO); end
    step(1'b1, 2'b00, '0);
`ifdef CONTADOR_PARAM_SAT_EN
    checks++; if (Q !== 16'hFFFF || RCO !== 1'b1 || RCO_NIB !== 4'b1000) begin errors++; $display("FAIL wrap2 got q=%h rco=%b nib=%b exp q=ffff rco=1 nib=1000", Q, RCO, RCO_NIB); end
`else
    checks++; if (Q !== 16'h0000 || RCO !== 1'b1 || RCO_NIB !== 4'b1111) begin errors++; $display("FAIL wrap2 got q=%h rco=%b nib=%b exp q=0000 rco=1 nib=1111", Q, RCO, RCO_NIB); end
    step(1'b1, 2'b00, '0);
    checks++; if (Q !== 16'h0001 || RCO !== 1'b0) begin errors++; $display("FAIL wrap3 got q=%h rco=%b exp q=0001 rco=0", Q, RCO); end
`endif
  endtask

  task automatic test_nibble_carry;
    load(16'h00FF);
    step(1'b1, 2'b00, '0);
    checks++; if (Q !== 16'h0100 || RCO !== 1'b0 || RCO_NIB !== 4'b0011) begin errors++; $display("FAIL nib_carry got q=%h rco=%b nib=%b exp q=0100 rco=0 nib=0011", Q, RCO, RCO_NIB); end
    load(16'h0100);
    step(1'b1, 2'b01, '0);
    checks++; if (Q !== 16'h00FF || RCO !== 1'b0 || RCO_NIB !== 4'b0011) begin errors++; $display("FAIL nib_borrow got q=%h rco=%b nib=%b exp q=00ff rco=0 nib=0011", Q, RCO, RCO_NIB); end
  endtask

  task automatic test_step_underflow;
    load(16'h0004);
    step(1'b1, 2'b10, '0);
    checks++; if (Q !== 16'h0001 || RCO !== 1'b0 || RCO_NIB !== 4'b0000) begin errors++; $display("FAIL step1 got q=%h rco=%b nib=%b exp q=0001 rco=0 nib=0000", Q, RCO, RCO_NIB); end
    step(1'b1, 2'b10, '0);
`ifdef CONTADOR_PARAM_SAT_EN
    checks++; if (Q !== 16'h0000 || RCO !== 1'b1 || RCO_NIB !== 4'b1000) begin errors++; $display("FAIL step2 got q=%h rco=%b nib=%b exp q=0000 rco=1 nib=1000", Q, RCO, RCO_NIB); end
`else
    checks++; if (Q !== 16'hFFFE || RCO !== 1'b1 || RCO_NIB !== 4'b1111) begin errors++; $display("FAIL step2 got q=%h rco=%b nib=%b exp q=fffe rco=1 nib=1111", Q, RCO, RCO_NIB); end
`endif
  endtask

  task automatic test_hold;
    load(16'h1234);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 2'b00, (i % 2 == 0) ? 16'hA5A5 : 16'h5A5A);
      checks++; if (Q !== 16'h1234 || RCO !== 1'b0 || RCO_NIB !== 4'b0000) begin errors++; $display("FAIL hold%0d got q=%h rco=%b nib=%b exp q=1234 rco=0 nib=0000", i, Q, RCO, RCO_NIB); end
    end
  endtask

  task automatic test_saturation;
    load(16'hFFFF);
    step(1'b1, 2'b00, '0);
`ifdef CONTADOR_PARAM_SAT_EN
    checks++; if (Q !== 16'hFFFF || RCO !== 1'b1) begin errors++; $display("FAIL sat1 got q=%h rco=%b exp q=ffff rco=1", Q, RCO); end
    step(1'b1, 2'b00, '0);
    checks++; if (Q !== 16'hFFFF || RCO !== 1'b1) begin errors++; $display("FAIL sat2 got q=%h rco=%b exp q=ffff rco=1", Q, RCO); end
`else
    checks++; if (Q !== 16'h0000 || RCO !== 1'b1) begin errors++; $display("FAIL sat1 got q=%h rco=%b exp q=0000 rco=1", Q, RCO); end
    step(1'b1, 2'b00, '0);
    checks++; if (Q !== 16'h0001 || RCO !== 1'b0) begin errors++; $display("FAIL sat2 got q=%h rco=%b exp q=0001 rco=0", Q, RCO); end
`endif
  endtask

  task automatic test_random;
    logic [W-1:0]  mq, eq, d;
    logic          erco, enb;
    logic [NB-1:0] enib;
    logic [1:0]    modo;
    mq = Q;
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 79) == 0) begin
        #2 RESET_L = 1'b0;
        #1;
        mq = '0;
        checks++; if (Q !== 16'h0000 || RCO !== 1'b0) begin errors++; $display("FAIL rnd_reset%0d got q=%h rco=%b exp q=0000 rco=0", n, Q, RCO); end
        @(negedge CLK);
        RESET_L = 1'b1;
      end
      enb  = ($urandom_range(0, 7) != 0);
      modo = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0:       d = 16'hFFFF - W'($urandom_range(0, 3));
        1:       d = W'($urandom_range(0, 4));
        2:       d = {W'($urandom_range(0, 15)) << 4} | 16'h000F;
        default: d = W'($urandom);
      endcase
      model(mq, enb, modo, d, eq, erco, enib);
      step(enb, modo, d);
      checks++;
      if (Q !== eq || RCO !== erco || RCO_NIB !== enib) begin
        errors++;
        $display("FAIL rnd%0d enb=%b modo=%b from=%h got q=%h rco=%b nib=%b exp q=%h rco=%b nib=%b",
                 n, enb, modo, mq, Q, RCO, RCO_NIB, eq, erco, enib);
      end
      mq = eq;
    end
  endtask

  initial begin
    test_reset();
    test_wrap();
    test_nibble_carry();
    test_step_underflow();
    test_hold();
    test_saturation();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
